fx_addsub_pipe: RTL and testbench

Parametrised fixed-point add/subtract/accumulate unit with operand format alignment, round-half-up, optional saturation and a configurable valid-qualified pipeline. It is the streaming successor of the fixed-format generated adders in the M2V datapath library. Operands may have different widths and fractional bits, and the output format is independent of both. It sits between generated DSP stages wherever a sum, a difference or a running sum is needed.

---
 rtl/fx_pkg.sv | 20 ++
 rtl/fx_round_sat.sv | 48 ++++
 rtl/fx_addsub_pipe.sv | 139 +++++++++++++
 tb/tb_fx_addsub_pipe.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/fx_pkg.sv
// Shared fixed-point helpers: mode encodings and format-derivation constant functions.
package fx_pkg;

    typedef enum logic [1:0] {
        FX_MODE_ADD  = 2'b00,
        FX_MODE_SUB  = 2'b01,
        FX_MODE_ACC  = 2'b10,
        FX_MODE_LOAD = 2'b11
    } fx_mode_e;

    function automatic int fx_max(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Width of the common internal format: one growth bit above the wider integer part.
    function automatic int fx_int_w(input int w1, input int f1, input int w2, input int f2);
        return fx_max(w1 - f1, w2 - f2) + 1 + fx_max(f1, f2);
    endfunction

endpackage

// File: rtl/fx_round_sat.sv
// Round-half-up and reduce a signed fixed-point value to a narrower output format.
// FX_ADDSUB_SAT_EN defined: out-of-range values saturate; otherwise they wrap.
module fx_round_sat #(
    parameter int IN_W  = 20,
    parameter int IN_F  = 10,
    parameter int OUT_W = 12,
    parameter int OUT_F = 8
) (
    input  logic signed [IN_W-1:0]  in_data,
    output logic        [OUT_W-1:0] out_data,
    output logic                    out_ovf
);

    localparam int SH    = IN_F - OUT_F;
    localparam int EXT_W = IN_W + 1;

    logic signed [EXT_W-1:0] rounded;
    logic signed [EXT_W-1:0] shifted;

    // One extra bit keeps the rounding increment from overflowing the input range.
    generate
        if (SH > 0) begin : g_round
            assign rounded = {in_data[IN_W-1], in_data} + EXT_W'(1 << (SH - 1));
        end else begin : g_exact
            assign rounded = {in_data[IN_W-1], in_data};
        end
    endgenerate

    assign shifted = rounded >>> SH;

    generate
        if (OUT_W < EXT_W) begin : g_reduce
            always_comb begin
                out_ovf  = !((&shifted[EXT_W-1:OUT_W-1]) || !(|shifted[EXT_W-1:OUT_W-1]));
                out_data = shifted[OUT_W-1:0];
`ifdef FX_ADDSUB_SAT_EN
                if (out_ovf)
                    out_data = shifted[EXT_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                                : {1'b0, {(OUT_W-1){1'b1}}};
`endif
            end
        end else begin : g_widen
            assign out_data = OUT_W'(shifted);
            assign out_ovf  = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/fx_addsub_pipe.sv
// Valid-qualified fixed-point add/sub/accumulate pipeline with format alignment.
// FX_ADDSUB_SAT_EN defined: accumulator and output reduction saturate instead of wrap.
module fx_addsub_pipe
    import fx_pkg::*;
#(
    parameter int IN1_W     = 13,
    parameter int IN1_F     = 10,
    parameter int IN2_W     = 13,
    parameter int IN2_F     = 8,
    parameter int OUT_W     = 12,
    parameter int OUT_F     = 8,
    parameter int ACC_GUARD = 4,
    parameter int LATENCY   = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [1:0]       i_mode,
    input  logic             i_clr,
    input  logic [IN1_W-1:0] i_data_1,
    input  logic [IN2_W-1:0] i_data_2,
    output logic             o_valid,
    output logic [OUT_W-1:0] o_data,
    output logic             o_ovf,
    output logic             o_ovf_sticky
);

    localparam int F_INT = fx_max(IN1_F, IN2_F);
    localparam int INT_W = fx_int_w(IN1_W, IN1_F, IN2_W, IN2_F);
    localparam int ACC_W = INT_W + ACC_GUARD;

    fx_mode_e mode;
    assign mode = fx_mode_e'(i_mode);

    logic signed [INT_W-1:0] a_al, b_al, addsub;
    assign a_al   = {{(INT_W-IN1_W){i_data_1[IN1_W-1]}}, i_data_1} << (F_INT - IN1_F);
    assign b_al   = {{(INT_W-IN2_W){i_data_2[IN2_W-1]}}, i_data_2} << (F_INT - IN2_F);
    assign addsub = (mode == FX_MODE_SUB) ? a_al - b_al : a_al + b_al;

    logic signed [ACC_W-1:0] acc_q, acc_base, acc_add, acc_d, a_acc, res_d, s1_res;
    logic                    s1_valid;

    assign a_acc    = ACC_W'(a_al);
    // Clear applies before the same-cycle sample.
    assign acc_base = i_clr ? '0 : acc_q;

`ifdef FX_ADDSUB_SAT_EN
    logic signed [ACC_W:0] acc_wide;
    assign acc_wide = (ACC_W+1)'(acc_base) + (ACC_W+1)'(a_acc);
    always_comb begin
        acc_add = acc_wide[ACC_W-1:0];
        if (acc_wide[ACC_W] != acc_wide[ACC_W-1])
            acc_add = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`else
    assign acc_add = acc_base + a_acc;
`endif

    always_comb begin
        acc_d = acc_base;
        res_d = ACC_W'(addsub);
        if (i_valid) begin
            case (mode)
                FX_MODE_ACC: begin
                    acc_d = acc_add;
                    res_d = acc_add;
                end
                FX_MODE_LOAD: begin
                    acc_d = a_acc;
                    res_d = a_acc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q    <= '0;
            s1_valid <= 1'b0;
            s1_res   <= '0;
        end else begin
            acc_q    <= acc_d;
            s1_valid <= i_valid;
            s1_res   <= res_d;
        end
    end

    logic [OUT_W-1:0] rs_data;
    logic             rs_ovf;

    fx_round_sat #(
        .IN_W (ACC_W),
        .IN_F (F_INT),
        .OUT_W(OUT_W),
        .OUT_F(OUT_F)
    ) u_round_sat (
        .in_data (s1_res),
        .out_data(rs_data),
        .out_ovf (rs_ovf)
    );

    logic             p_valid [2:LATENCY];
    logic [OUT_W-1:0] p_data  [2:LATENCY];
    logic             p_ovf   [2:LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 2; i <= LATENCY; i++) begin
                p_valid[i] <= 1'b0;
                p_data[i]  <= '0;
                p_ovf[i]   <= 1'b0;
            end
        end else begin
            p_valid[2] <= s1_valid;
            p_data[2]  <= rs_data;
            p_ovf[2]   <= s1_valid & rs_ovf;
            for (int unsigned i = 3; i <= LATENCY; i++) begin
                p_valid[i] <= p_valid[i-1];
                p_data[i]  <= p_data[i-1];
                p_ovf[i]   <= p_ovf[i-1];
            end
        end
    end

    assign o_valid = p_valid[LATENCY];
    assign o_data  = p_data[LATENCY];
    assign o_ovf   = p_ovf[LATENCY];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            o_ovf_sticky <= 1'b0;
        else if (o_valid && o_ovf)
            o_ovf_sticky <= 1'b1;
        else if (i_clr)
            o_ovf_sticky <= 1'b0;
    end

endmodule

// File: tb/tb_fx_addsub_pipe.sv
// Directed bench for fx_addsub_pipe at LATENCY 2 and 4; honours FX_ADDSUB_SAT_EN.
module tb_fx_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        clr = 1'b0;
    logic [12:0] a = '0;
    logic [12:0] b = '0;

    logic        v2, ovf2, st2, v4, ovf4, st4;
    logic [11:0] d2, d4;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fx_addsub_pipe #(.LATENCY(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mode(mode), .i_clr(clr),
        .i_data_1(a), .i_data_2(b),
        .o_valid(v2), .o_data(d2), .o_ovf(ovf2), .o_ovf_sticky(st2)
    );

    fx_addsub_pipe #(.LATENCY(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_mode(mode), .i_clr(clr),
        .i_data_1(a), .i_data_2(b),
        .o_valid(v4), .o_data(d4), .o_ovf(ovf4), .o_ovf_sticky(st4)
    );

`ifdef FX_ADDSUB_SAT_EN
    localparam logic [11:0] POS_BIG = 12'h7FF;
    localparam logic [11:0] NEG_BIG = 12'h800;
`else
    localparam logic [11:0] POS_BIG = 12'h3FF;
    localparam logic [11:0] NEG_BIG = 12'hC00;
`endif

    typedef struct {
        logic [1:0]  mode;
        logic [12:0] a;
        logic [12:0] b;
        logic [11:0] data;
        logic        ovf;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [11:0] data;
        logic        ovf;
    } obs_t;

    obs_t got2[$], got4[$], exp2[$], exp4[$];

    always @(negedge clk) begin
        obs_t o;
        o.cyc = cyc;
        if (v2) begin
            o.data = d2; o.ovf = ovf2;
            got2.push_back(o);
        end
        if (v4) begin
            o.data = d4; o.ovf = ovf4;
            got4.push_back(o);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [12:0] x,
                         input logic [12:0] y, input logic c, output int c_drv);
        @(negedge clk);
        c_drv = cyc;
        valid = v; mode = m; a = x; b = y; clr = c;
    endtask

    task automatic expect_out(input int c_drv, input logic [11:0] data, input logic ovf);
        obs_t o;
        o.data = data; o.ovf = ovf;
        o.cyc = c_drv + 2; exp2.push_back(o);
        o.cyc = c_drv + 4; exp4.push_back(o);
    endtask

    task automatic clear_streams();
        got2.delete(); got4.delete(); exp2.delete(); exp4.delete();
    endtask

    task automatic cmp_streams(input string name);
        chk({name, "_count_l2"}, got2.size(), exp2.size());
        for (int i = 0; i < exp2.size() && i < got2.size(); i++) begin
            chk({name, "_cyc_l2"}, got2[i].cyc, exp2[i].cyc);
            chk({name, "_data_l2"}, got2[i].data, exp2[i].data);
            chk({name, "_ovf_l2"}, got2[i].ovf, exp2[i].ovf);
        end
        chk({name, "_count_l4"}, got4.size(), exp4.size());
        for (int i = 0; i < exp4.size() && i < got4.size(); i++) begin
            chk({name, "_cyc_l4"}, got4[i].cyc, exp4[i].cyc);
            chk({name, "_data_l4"}, got4[i].data, exp4[i].data);
            chk({name, "_ovf_l4"}, got4[i].ovf, exp4[i].ovf);
        end
        clear_streams();
    endtask

    vec_t vecs[8];

    initial begin
        int  c;
        logic exp_st;

        vecs[0] = '{2'b00, 13'h0400, 13'h0080, 12'h180, 1'b0};  // 1.0 + 0.5
        vecs[1] = '{2'b01, 13'h0000, 13'h0080, 12'hF80, 1'b0};  // 0 - 0.5
        vecs[2] = '{2'b00, 13'h0001, 13'h0000, 12'h000, 1'b0};  // below half lsb
        vecs[3] = '{2'b00, 13'h0002, 13'h0000, 12'h001, 1'b0};  // exact half rounds up
        vecs[4] = '{2'b01, 13'h0400, 13'h0100, 12'h000, 1'b0};  // 1.0 - 1.0
        vecs[5] = '{2'b00, 13'h0FFF, 13'h0FFF, POS_BIG, 1'b1};
        vecs[6] = '{2'b00, 13'h1000, 13'h1000, NEG_BIG, 1'b1};
        vecs[7] = '{2'b11, 13'h0C00, 13'h0FFF, 12'h300, 1'b0};  // load 3.0, b ignored

        repeat (3) @(negedge clk);
        chk("rst_valid_l2", v2, 1'b0);
        chk("rst_data_l2", d2, 12'h000);
        chk("rst_ovf_l2", ovf2, 1'b0);
        chk("rst_sticky_l2", st2, 1'b0);
        chk("rst_valid_l4", v4, 1'b0);
        chk("rst_data_l4", d4, 12'h000);
        chk("rst_ovf_l4", ovf4, 1'b0);
        chk("rst_sticky_l4", st4, 1'b0);
        rst_n = 1'b1;

        exp_st = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].mode, vecs[i].a, vecs[i].b, 1'b0, c);
            drive(1'b0, 2'b00, 13'h0, 13'h0, 1'b0, c);
            chk("vec_early_l2", v2, 1'b0);
            @(negedge clk);
            chk("vec_valid_l2", v2, 1'b1);
            chk("vec_data_l2", d2, vecs[i].data);
            chk("vec_ovf_l2", ovf2, vecs[i].ovf);
            @(negedge clk);
            exp_st = exp_st | vecs[i].ovf;
            chk("vec_sticky_l2", st2, exp_st);
            chk("vec_early_l4", v4, 1'b0);
            @(negedge clk);
            chk("vec_valid_l4", v4, 1'b1);
            chk("vec_data_l4", d4, vecs[i].data);
            chk("vec_ovf_l4", ovf4, vecs[i].ovf);
            @(negedge clk);
        end

        // Clear with accumulate: prior acc of 3.0 must be dropped; sticky clears.
        clear_streams();
        drive(1'b1, 2'b10, 13'h0400, 13'h1FFF, 1'b1, c); expect_out(c, 12'h100, 1'b0);
        drive(1'b1, 2'b10, 13'h0400, 13'h0000, 1'b0, c); expect_out(c, 12'h200, 1'b0);
        chk("clr_sticky_l2", st2, 1'b0);
        chk("clr_sticky_l4", st4, 1'b0);
        drive(1'b1, 2'b10, 13'h0400, 13'h0000, 1'b0, c); expect_out(c, 12'h300, 1'b0);
        drive(1'b1, 2'b10, 13'h0400, 13'h0000, 1'b0, c); expect_out(c, 12'h400, 1'b0);
        drive(1'b1, 2'b11, 13'h0000, 13'h0AAA, 1'b0, c); expect_out(c, 12'h000, 1'b0);
        drive(1'b0, 2'b00, 13'h0, 13'h0, 1'b0, c);
        repeat (6) @(negedge clk);
        cmp_streams("acc");

        // Bubble pattern 1,0,1,1.
        drive(1'b1, 2'b00, 13'h0400, 13'h0000, 1'b0, c); expect_out(c, 12'h100, 1'b0);
        drive(1'b0, 2'b00, 13'h0, 13'h0, 1'b0, c);
        drive(1'b1, 2'b00, 13'h0800, 13'h0000, 1'b0, c); expect_out(c, 12'h200, 1'b0);
        drive(1'b1, 2'b01, 13'h0000, 13'h0080, 1'b0, c); expect_out(c, 12'hF80, 1'b0);
        drive(1'b0, 2'b00, 13'h0, 13'h0, 1'b0, c);
        repeat (6) @(negedge clk);
        cmp_streams("bubble");

        // Reset with accumulate samples in flight; acc must restart from zero.
        drive(1'b1, 2'b10, 13'h0400, 13'h0000, 1'b0, c);
        drive(1'b1, 2'b10, 13'h0400, 13'h0000, 1'b0, c);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        valid = 1'b0;
        #1;
        chk("midrst_valid_l2", v2, 1'b0);
        chk("midrst_valid_l4", v4, 1'b0);
        chk("midrst_sticky_l2", st2, 1'b0);
        clear_streams();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        cmp_streams("no_stale");
        drive(1'b1, 2'b10, 13'h0400, 13'h0000, 1'b0, c); expect_out(c, 12'h100, 1'b0);
        drive(1'b0, 2'b00, 13'h0, 13'h0, 1'b0, c);
        repeat (6) @(negedge clk);
        cmp_streams("post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
